// File: rtl/sync_generator.sv
// Raster timing generator: hsync/vsync/blank, pixel coordinates and a frame pulse from clk_50mhz_in.
// Define SYNC_GENERATOR_CSYNC_EN to add a registered composite sync on csync_out.
module sync_generator #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int CLK_DIV  = 2,
   parameter int SYNC_POL = 0
) (
   input  logic        clk_50mhz_in,
   input  logic        reset_n_in,
   input  logic        enable_in,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        blank_out,
   output logic [10:0] pixel_x_out,
   output logic [9:0]  pixel_y_out,
   output logic        frame_start_out,
   output logic        csync_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [10:0]      H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [11:0]      H_ACT_END  = 12'(H_ACTIVE);
   localparam logic [11:0]      H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0]      H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0]      V_ACT_END  = 11'(V_ACTIVE);
   localparam logic [10:0]      V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0]      V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic             SYNC_ON    = (SYNC_POL != 0);
   localparam logic             SYNC_OFF   = !SYNC_ON;

   logic [DIV_W-1:0] div_cnt;
   logic [10:0]      h_cnt;
   logic [9:0]       v_cnt;
   logic             run_q;
   logic [11:0]      h_ext;
   logic [10:0]      v_ext;
   logic             idle;
   logic             pix_ce;
   logic             h_wrap;
   logic             v_wrap;
   logic             hs_act;
   logic             vs_act;
   logic             act_area;
   logic             at_origin;

   always_comb begin
      h_ext     = {1'b0, h_cnt};
      v_ext     = {1'b0, v_cnt};
      idle      = !reset_n_in || !enable_in || !run_q;
      pix_ce    = (div_cnt == DIV_LAST);
      h_wrap    = (h_cnt == H_LAST);
      v_wrap    = (v_cnt == V_LAST);
      hs_act    = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
      vs_act    = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
      act_area  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
      at_origin = pix_ce && (h_cnt == '0) && (v_cnt == '0);
   end

   // Reset leaves the counters at the origin ready to run on the next edge;
   // an enable rise spends its first edge re-arming so the restart matches reset.
   always_ff @(posedge clk_50mhz_in) begin
      if (idle) begin
         div_cnt         <= '0;
         h_cnt           <= '0;
         v_cnt           <= '0;
         run_q           <= !reset_n_in || enable_in;
         hsync_out       <= SYNC_OFF;
         vsync_out       <= SYNC_OFF;
         blank_out       <= 1'b1;
         pixel_x_out     <= '0;
         pixel_y_out     <= '0;
         frame_start_out <= 1'b0;
      end else begin
         hsync_out       <= hs_act ? SYNC_ON : SYNC_OFF;
         vsync_out       <= vs_act ? SYNC_ON : SYNC_OFF;
         blank_out       <= !act_area;
         pixel_x_out     <= h_cnt;
         pixel_y_out     <= v_cnt;
         frame_start_out <= at_origin;
         if (pix_ce) begin
            div_cnt <= '0;
            if (h_wrap) begin
               h_cnt <= '0;
               v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 11'd1;
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

`ifdef SYNC_GENERATOR_CSYNC_EN
   // Composite sync: hsync pulses, inverted while inside the vsync lines.
   always_ff @(posedge clk_50mhz_in) begin
      if (idle) begin
         csync_out <= SYNC_OFF;
      end else begin
         csync_out <= (hs_act ^ vs_act) ? SYNC_ON : SYNC_OFF;
      end
   end
`else
   assign csync_out = SYNC_OFF;
`endif

endmodule

// File: tb/tb_sync_generator.sv
// Bench for sync_generator: three instances (defaults, fast/positive, divide-by-3) against
// an arithmetic raster model, plus hand-computed timing pins.
module tb_sync_generator;

   localparam int ND = 3;
   localparam int P_HA  [ND] = '{640, 10, 12};
   localparam int P_HF  [ND] = '{16, 2, 3};
   localparam int P_HS  [ND] = '{96, 3, 4};
   localparam int P_HB  [ND] = '{48, 5, 5};
   localparam int P_VA  [ND] = '{480, 6, 5};
   localparam int P_VF  [ND] = '{10, 1, 2};
   localparam int P_VS  [ND] = '{2, 2, 3};
   localparam int P_VB  [ND] = '{33, 3, 2};
   localparam int P_CD  [ND] = '{2, 1, 3};
   localparam int P_POL [ND] = '{0, 1, 0};

   logic          clk_50mhz_in = 1'b0;
   logic          reset_n_in;
   logic          enable_in;
   logic [ND-1:0] hs, vs, bl, fs, cs;
   logic [10:0]   px [ND];
   logic [9:0]    py [ND];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   tick [ND] = '{-1, -1, -1};
   bit   valid = 1'b0;
   logic e_hs [ND], e_vs [ND], e_bl [ND], e_fs [ND], e_cs [ND];
   int   e_px [ND], e_py [ND];

   always #10 clk_50mhz_in = ~clk_50mhz_in;

   sync_generator u_a (
      .clk_50mhz_in(clk_50mhz_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
      .hsync_out(hs[0]), .vsync_out(vs[0]), .blank_out(bl[0]),
      .pixel_x_out(px[0]), .pixel_y_out(py[0]),
      .frame_start_out(fs[0]), .csync_out(cs[0]));

   sync_generator #(
      .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
      .CLK_DIV(1), .SYNC_POL(1)
   ) u_b (
      .clk_50mhz_in(clk_50mhz_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
      .hsync_out(hs[1]), .vsync_out(vs[1]), .blank_out(bl[1]),
      .pixel_x_out(px[1]), .pixel_y_out(py[1]),
      .frame_start_out(fs[1]), .csync_out(cs[1]));

   sync_generator #(
      .H_ACTIVE(12), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
      .V_ACTIVE(5), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
      .CLK_DIV(3), .SYNC_POL(0)
   ) u_c (
      .clk_50mhz_in(clk_50mhz_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
      .hsync_out(hs[2]), .vsync_out(vs[2]), .blank_out(bl[2]),
      .pixel_x_out(px[2]), .pixel_y_out(py[2]),
      .frame_start_out(fs[2]), .csync_out(cs[2]));

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   // Outputs for the t-th running clock since the timing origin.
   function automatic void model_out(input int d, input int t,
                                     output logic o_hs, output logic o_vs, output logic o_bl,
                                     output logic o_fs, output logic o_cs,
                                     output int o_px, output int o_py);
      int   ht, vt, p, h, v;
      logic ha, va, on;
      ht   = P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
      vt   = P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d];
      p    = t / P_CD[d];
      h    = p % ht;
      v    = (p / ht) % vt;
      ha   = (h >= P_HA[d] + P_HF[d]) && (h < P_HA[d] + P_HF[d] + P_HS[d]);
      va   = (v >= P_VA[d] + P_VF[d]) && (v < P_VA[d] + P_VF[d] + P_VS[d]);
      on   = (P_POL[d] != 0);
      o_hs = ha ? on : !on;
      o_vs = va ? on : !on;
      o_bl = !((h < P_HA[d]) && (v < P_VA[d]));
      o_fs = ((t % P_CD[d]) == P_CD[d] - 1) && ((p % (ht * vt)) == 0);
`ifdef SYNC_GENERATOR_CSYNC_EN
      o_cs = (ha ^ va) ? on : !on;
`else
      o_cs = !on;
`endif
      o_px = h;
      o_py = v;
   endfunction

   // tick = running clocks since origin; -1 while idle (enable low).
   always @(posedge clk_50mhz_in) begin
      for (int d = 0; d < ND; d++) begin
         if (!reset_n_in || !enable_in || tick[d] < 0) begin
            e_hs[d] = (P_POL[d] == 0);
            e_vs[d] = (P_POL[d] == 0);
            e_cs[d] = (P_POL[d] == 0);
            e_bl[d] = 1'b1;
            e_fs[d] = 1'b0;
            e_px[d] = 0;
            e_py[d] = 0;
            tick[d] = (!reset_n_in || enable_in) ? 0 : -1;
            if (!reset_n_in) valid = 1'b1;
         end else begin
            model_out(d, tick[d], e_hs[d], e_vs[d], e_bl[d], e_fs[d], e_cs[d], e_px[d], e_py[d]);
            tick[d]++;
         end
      end
   end

   always @(negedge clk_50mhz_in) begin
      if (valid) begin
         for (int d = 0; d < ND; d++) begin
            check("hsync", d, 32'(hs[d]), 32'(e_hs[d]));
            check("vsync", d, 32'(vs[d]), 32'(e_vs[d]));
            check("blank", d, 32'(bl[d]), 32'(e_bl[d]));
            check("frame_start", d, 32'(fs[d]), 32'(e_fs[d]));
            check("csync", d, 32'(cs[d]), 32'(e_cs[d]));
            check("pixel_x", d, 32'(px[d]), e_px[d]);
            check("pixel_y", d, 32'(py[d]), e_py[d]);
         end
      end
   end

   initial begin
      int   a_f1, a_f2, a_lw, a_low, b_hw, b_high, b_z1, b_z2, c_f1, c_f2, n, act;
      logic a_prev;
      a_f1 = -1; a_f2 = -1; a_lw = -1; a_low = 0;
      b_hw = -1; b_high = 0; b_z1 = -1; b_z2 = -1; c_f1 = -1; c_f2 = -1;
      reset_n_in = 1'b0;
      enable_in  = 1'b1;
      repeat (3) @(posedge clk_50mhz_in);
      #1 reset_n_in = 1'b1;

      // Timing pins measured in edges after the last reset edge.
      a_prev = hs[0];
      for (int k = 1; k <= 3400; k++) begin
         @(posedge clk_50mhz_in); #1;
         if (a_prev && !hs[0]) begin
            if (a_f1 < 0) a_f1 = k;
            else if (a_f2 < 0) a_f2 = k;
         end
         if (!hs[0]) a_low++;
         else if (a_low > 0) begin
            if (a_lw < 0) a_lw = a_low;
            a_low = 0;
         end
         if (hs[1]) b_high++;
         else if (b_high > 0) begin
            if (b_hw < 0) b_hw = b_high;
            b_high = 0;
         end
         if (px[1] == 11'd0) begin
            if (b_z1 < 0) b_z1 = k;
            else if (b_z2 < 0) b_z2 = k;
         end
         if (fs[2]) begin
            if (c_f1 < 0) c_f1 = k;
            else if (c_f2 < 0) c_f2 = k;
         end
         a_prev = hs[0];
      end
      check("a_first_hsync", 0, a_f1, 1313);
      check("a_hsync_period", 0, a_f2 - a_f1, 1600);
      check("a_hsync_width", 0, a_lw, 192);
      check("b_hsync_width", 1, b_hw, 3);
      check("b_line_period", 1, b_z2 - b_z1, 20);
      check("c_first_frame", 2, c_f1, 3);
      check("c_frame_period", 2, c_f2 - c_f1, 864);

      // Enable dropped mid-line, then re-enabled.
      n = 0;
      while (px[0] != 11'd300 && n < 2000) begin
         @(posedge clk_50mhz_in); #1;
         n++;
      end
      enable_in = 1'b0;
      @(posedge clk_50mhz_in); #1;
      check("idle_hsync", 0, 32'(hs[0]), 1);
      check("idle_blank", 0, 32'(bl[0]), 1);
      check("idle_x", 0, 32'(px[0]), 0);
      repeat (4) @(posedge clk_50mhz_in);
      #1 enable_in = 1'b1;
      n = 0;
      do begin
         @(posedge clk_50mhz_in); #1;
         n++;
      end while (!fs[0] && n < 10);
      check("a_reenable_frame", 0, n, 3);

      // One-clock reset pulse inside the vsync lines of instance b.
      n = 0;
      while (!vs[1] && n < 600) begin
         @(posedge clk_50mhz_in); #1;
         n++;
      end
      check("b_in_vsync", 1, 32'(vs[1]), 1);
      reset_n_in = 1'b0;
      @(posedge clk_50mhz_in); #1;
      reset_n_in = 1'b1;
      check("rst_vsync_b", 1, 32'(vs[1]), 0);
      check("rst_x_a", 0, 32'(px[0]), 0);
      check("rst_blank_c", 2, 32'(bl[2]), 1);
      n = 0;
      do begin
         @(posedge clk_50mhz_in); #1;
         n++;
      end while (hs[0] && n < 1400);
      check("a_hsync_after_rst", 0, n, 1313);

      // Random mix of runs, reset pulses and enable drops.
      for (int it = 0; it < 60; it++) begin
         act = $urandom_range(0, 9);
         if (act < 2) begin
            reset_n_in = 1'b0;
            enable_in  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(posedge clk_50mhz_in);
            #1;
            reset_n_in = 1'b1;
            enable_in  = 1'b1;
         end else if (act < 4) begin
            enable_in = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge clk_50mhz_in);
            #1 enable_in = 1'b1;
         end else begin
            repeat ($urandom_range(1, 1500)) @(posedge clk_50mhz_in);
            #1;
         end
      end

      repeat (2) @(posedge clk_50mhz_in);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
